// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic sequential accumulator.
// Holds the FSM state encoding and the accumulator width derivation so the
// top level and any wrapper agree on the result width.
package da_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StOffset,
        StDone
    } da_state_e;

    // One bit above the LUT sum for the negated term, plus DATA_WIDTH_A bits of
    // shift-and-add growth across the bit-serial pass.
    function automatic int unsigned acc_width(input int unsigned lut_width,
                                              input int unsigned data_width_a);
        return lut_width + 1 + data_width_a;
    endfunction

endpackage

// File: rtl/da_addr_slice.sv
// Offset-binary address generator for one bit slice.
// Ports:
//   bits_i : bit j of every activation, bits_i[k] = A[k][j]
//   addr_o : LUT address, addr_o[k-1] set when A[k][j] matches A[0][j]
//   neg_o  : set when the LUT sum must be negated (A[0][j] is zero)
// Operand 0 is always taken with a plus sign inside the LUT, so the other
// operands are encoded relative to it and the common sign is pulled out.
module da_addr_slice #(
    parameter int unsigned K = 4
) (
    input  logic [K-1:0] bits_i,
    output logic [K-2:0] addr_o,
    output logic         neg_o
);

    always_comb begin
        addr_o = '0;
        for (int k = 1; k < K; k++) begin
            addr_o[k-1] = ~(bits_i[k] ^ bits_i[0]);
        end
        neg_o = ~bits_i[0];
    end

endmodule

// File: rtl/da_seq_acc.sv
// Bit-serial distributed-arithmetic dot product, sum over k of A[k]*B[k].
// The weights live in an external LUT addressed by one activation bit slice
// per cycle; this block walks the slices MSB-first and accumulates the
// signed LUT responses, then applies the offset-binary correction term.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   in_valid, in_ready : operand handshake, A latched on acceptance
//   A                  : K signed activations
//   addr_array         : registered LUT address for the current slice
//   gen_done           : registered strobe, high while addr_array is live
//   LUT_out            : combinational LUT response to addr_array
//   result             : signed dot product, held while out_valid
//   out_valid, out_ready : result handshake
module da_seq_acc
    import da_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_A = 8,
    parameter int unsigned DATA_WIDTH_B = 8,
    parameter int unsigned K            = 4,
    parameter int unsigned LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
    parameter int unsigned ACC_WIDTH    = acc_width(LUT_WIDTH, DATA_WIDTH_A)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH_A-1:0] A [K],
    output logic        [K-2:0]            addr_array,
    output logic                           gen_done,
    input  logic signed [LUT_WIDTH:0]      LUT_out,
    output logic signed [ACC_WIDTH-1:0]    result,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned JW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
    localparam logic [JW-1:0] JMax = JW'(DATA_WIDTH_A - 1);

    da_state_e                      state_q;
    logic signed [DATA_WIDTH_A-1:0] a_q [K];
    logic [JW-1:0]                  j_q;
    logic                           last_bit_q;   // bit 0 already issued
    logic [K-2:0]                   addr_q;
    logic                           neg_q;
    logic                           gen_q;
    logic                           first_q;      // addr_q holds the MSB slice
    logic                           off_q;        // addr_q holds the offset slice
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic                           in_ready_q;
    logic                           out_valid_q;

    logic [K-1:0]                   slice_bits;
    logic [K-2:0]                   slice_addr;
    logic                           slice_neg;
    logic signed [ACC_WIDTH-1:0]    lut_ext;
    logic signed [ACC_WIDTH-1:0]    term;

    always_comb begin
        slice_bits = '0;
        for (int k = 0; k < K; k++) begin
            slice_bits[k] = a_q[k][j_q];
        end
    end

    da_addr_slice #(
        .K (K)
    ) u_addr_slice (
        .bits_i (slice_bits),
        .addr_o (slice_addr),
        .neg_o  (slice_neg)
    );

    // neg_q is registered alongside addr_q, so it matches the LUT response.
    always_comb begin
        lut_ext = {{(ACC_WIDTH - LUT_WIDTH - 1){LUT_out[LUT_WIDTH]}}, LUT_out};
        term    = neg_q ? -lut_ext : lut_ext;
    end

    // Address issue runs one cycle ahead of accumulation: the slice registered
    // on one edge is consumed from LUT_out on the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            for (int k = 0; k < K; k++) begin
                a_q[k] <= '0;
            end
            j_q         <= '0;
            last_bit_q  <= 1'b0;
            addr_q      <= '0;
            neg_q       <= 1'b0;
            gen_q       <= 1'b0;
            first_q     <= 1'b0;
            off_q       <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (gen_q) begin
                if (first_q) begin
                    // MSB carries negative weight in two's complement.
                    acc_q <= -term;
                end else if (off_q) begin
                    acc_q <= acc_q + term;
                end else begin
                    acc_q <= (acc_q <<< 1) + term;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        acc_q      <= '0;
                        j_q        <= JMax;
                        last_bit_q <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    gen_q <= 1'b1;
                    if (last_bit_q) begin
                        // Offset slice: all operands positive, then negated.
                        addr_q  <= '1;
                        neg_q   <= 1'b1;
                        first_q <= 1'b0;
                        off_q   <= 1'b1;
                        state_q <= StOffset;
                    end else begin
                        addr_q  <= slice_addr;
                        neg_q   <= slice_neg;
                        first_q <= (j_q == JMax);
                        off_q   <= 1'b0;
                        if (j_q == '0) begin
                            last_bit_q <= 1'b1;
                        end else begin
                            j_q <= j_q - JW'(1);
                        end
                    end
                end
                StOffset: begin
                    gen_q       <= 1'b0;
                    addr_q      <= '0;
                    neg_q       <= 1'b0;
                    off_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign addr_array = addr_q;
    assign gen_done   = gen_q;
    assign result     = acc_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_da_seq_acc.sv
// Directed bench for da_seq_acc with a behavioural weight LUT.
module tb_da_seq_acc;

    localparam int unsigned W  = 8;
    localparam int unsigned WB = 8;
    localparam int unsigned KK = 4;
    localparam int unsigned LW = WB + $clog2(KK);
    localparam int unsigned AW = LW + 1 + W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   a_in [KK];
    logic signed [WB-1:0]  b_v [KK];
    logic [KK-2:0]         addr_array;
    logic                  gen_done;
    logic signed [LW:0]    lut;
    logic signed [AW-1:0]  result;
    logic                  out_valid;
    logic                  out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    da_seq_acc #(
        .DATA_WIDTH_A (W),
        .DATA_WIDTH_B (WB),
        .K            (KK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (a_in),
        .addr_array (addr_array),
        .gen_done   (gen_done),
        .LUT_out    (lut),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Sum of +/-(B[k]>>>1): operand 0 always plus, others by address bit.
    always_comb begin
        int s;
        int h;
        s   = 0;
        h   = 0;
        lut = '0;
        if (gen_done) begin
            for (int k = 0; k < KK; k++) begin
                h = b_v[k];
                h = h >>> 1;
                if (k == 0) s += h;
                else if (addr_array[k-1]) s += h;
                else s -= h;
            end
            lut = s[LW:0];
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_a(input int a0, input int a1, input int a2, input int a3);
        a_in[0] = W'(a0);
        a_in[1] = W'(a1);
        a_in[2] = W'(a2);
        a_in[3] = W'(a3);
    endtask

    task automatic load_b(input int b0, input int b1, input int b2, input int b3);
        b_v[0] = WB'(b0);
        b_v[1] = WB'(b1);
        b_v[2] = WB'(b2);
        b_v[3] = WB'(b3);
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic start_op(input string tag, input bit hold);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = hold;
        check({tag, ".accept"}, in_ready, 0);
    endtask

    // Called #1 after the accept edge; walks edges until out_valid.
    task automatic wait_out(input string tag, input longint exp_res);
        int lat;
        int gens;
        bit seen;
        lat  = 0;
        gens = 0;
        seen = 1'b0;
        if (gen_done) gens++;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (gen_done) gens++;
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, ".out_valid_seen"}, seen, 1);
        check({tag, ".latency"}, lat, W + 2);
        check({tag, ".gen_done_cycles"}, gens, W + 1);
        check({tag, ".result"}, result, exp_res);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".hs_out_valid"}, out_valid, 0);
        check({tag, ".hs_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_a(0, 0, 0, 0);
        load_b(0, 0, 0, 0);
        #1;
        check("rst.gen_done", gen_done, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.addr", addr_array, 0);
        check("rst.result", result, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.in_ready", in_ready, 1);
        check("post_rst.gen_done", gen_done, 0);

        load_b(2, 4, 6, 8);
        load_a(1, 2, 3, 4);
        start_op("basic", 1'b0);
        wait_out("basic", 60);
        handshake("basic");

        load_b(-128, -128, -128, -128);
        load_a(-128, -128, -128, -128);
        start_op("worst", 1'b0);
        wait_out("worst", 65536);
        handshake("worst");

        load_b(2, -2, 4, -6);
        load_a(127, -1, 0, 5);
        start_op("mixed", 1'b0);
        wait_out("mixed", 226);
        handshake("mixed");

        load_b(2, 4, 6, 8);
        load_a(0, 0, 0, 0);
        start_op("zero", 1'b0);
        wait_out("zero", 0);
        handshake("zero");

        load_b(2, 2, 2, 2);
        load_a(-1, -1, -1, -1);
        start_op("neg1", 1'b0);
        wait_out("neg1", -8);
        handshake("neg1");

        // Stall in DONE with a competing request on the input.
        load_b(2, 4, 6, 8);
        load_a(1, 2, 3, 4);
        start_op("stall", 1'b0);
        wait_out("stall", 60);
        load_a(9, 9, 9, 9);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall.out_valid", out_valid, 1);
            check("stall.result", result, 60);
            check("stall.in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake("stall");
        @(posedge clk);
        #1;
        check("stall.idle_in_ready", in_ready, 1);

        // Reset in the middle of the bit-serial pass.
        load_a(5, 6, 7, 8);
        start_op("midrst", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        #1;
        check("midrst.gen_before", gen_done, 1);
        rst = 1'b0;
        #1;
        check("midrst.gen_done", gen_done, 0);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.result", result, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("midrst.in_ready", in_ready, 1);
        load_a(1, 2, 3, 4);
        start_op("after_rst", 1'b0);
        wait_out("after_rst", 60);
        handshake("after_rst");

        // Back-to-back with in_valid held high throughout.
        load_a(1, 2, 3, 4);
        start_op("b2b1", 1'b1);
        load_a(-1, -1, -1, -1);
        wait_out("b2b1", 60);
        handshake("b2b1");
        @(posedge clk);
        #1;
        check("b2b2.accept_next", in_ready, 0);
        in_valid = 1'b0;
        wait_out("b2b2", -20);
        handshake("b2b2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/da_seq_acc.md
DA_SEQ_ACC -- requirements
Module: da_seq_acc

Interface
REQ-001 SHALL have parameters: DATA_WIDTH_A, default 8, activation width; DATA_WIDTH_B, default 8, weight width; K, default 4, operand count, multiple of 4.
REQ-002 SHALL have parameters: LUT_WIDTH, default DATA_WIDTH_B+$clog2(K), LUT sum width less one; ACC_WIDTH, default LUT_WIDTH+1+DATA_WIDTH_A, result width.
REQ-003 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; A in K x DATA_WIDTH_A signed, activation vector.
REQ-005 SHALL have ports: addr_array out K-1, bit-slice address to LUT; gen_done out 1, address-valid strobe to LUT.
REQ-006 SHALL have ports: LUT_out in LUT_WIDTH+1 signed, same-cycle combinational LUT response.
REQ-007 SHALL have ports: result out ACC_WIDTH signed; out_valid out 1; out_ready in 1.

Function
REQ-008 SHALL use FSM states IDLE, RUN, OFFSET, DONE.
REQ-009 SHALL assert in_ready only in IDLE; on in_valid&&in_ready SHALL latch A, clear accumulator, set bit index j=DATA_WIDTH_A-1, and go to RUN.
REQ-010 In RUN, for bit j, SHALL drive addr_array[k-1] = ~(A[k][j] ^ A[0][j]) for k=1..K-1, and SHALL set internal neg = ~A[0][j].
REQ-011 SHALL register addr_array, neg and gen_done, so LUT_out corresponds to the registered address in the same cycle.
REQ-012 SHALL form term T = neg ? -LUT_out : LUT_out, sign-extended to ACC_WIDTH.
REQ-013 SHALL accumulate MSB-first: first bit cycle acc = -T; later bit cycles acc = (acc<<<1) + T; j decrements each cycle.
REQ-014 After j=0, SHALL go to OFFSET for one cycle with addr_array all ones and neg=1, and SHALL compute acc = acc + T with no shift.
REQ-015 SHALL hold gen_done high for exactly DATA_WIDTH_A+1 consecutive cycles per operation, and low otherwise.
REQ-016 Net result SHALL equal sum over k of A[k]*B[k] whenever every B[k] is even.
REQ-017 SHALL go OFFSET->DONE; in DONE, out_valid=1 and result held stable until out_ready.
REQ-018 out_valid&&out_ready SHALL return FSM to IDLE; in_ready rises next cycle, with no back-to-back overlap.
REQ-019 Latency SHALL be: accept at edge T0; gen_done high T0+1..T0+DATA_WIDTH_A+1; out_valid at T0+DATA_WIDTH_A+2.
REQ-020 SHALL ignore in_valid outside IDLE, and SHALL ignore LUT_out while gen_done is low.
REQ-021 Accumulator SHALL NOT saturate; ACC_WIDTH covers the worst case, e.g. all A=-2^(W-1) and all B=-2^(W-1).

Reset
REQ-022 rst low SHALL immediately force IDLE, with in_ready=1 after release, and gen_done=0, addr_array=0, out_valid=0, result=0, acc=0.
REQ-023 Reset mid-RUN or mid-DONE SHALL discard the operation; the first cycle after release SHALL be IDLE.

Structure
REQ-024 Package da_pkg SHALL hold the FSM state enum typedef and the ACC_WIDTH derivation constant/function.
REQ-025 Sub-module da_addr_slice, combinational, SHALL map the K bits of slice j to {addr_array, neg}.
REQ-026 The bench SHALL connect a behavioural LUT model to LUT_out: sum of ±(B[k]>>>1), with sign + for k=0 and by addr bit for k>0, gated to 0 when gen_done is low.

Verification
REQ-027 SHALL cover: K=4, W=8, A={1,2,3,4}, B={2,4,6,8} -> result=60; out_valid 10 cycles after accept; gen_done high for 9 cycles.
REQ-028 SHALL cover: A={-128,-128,-128,-128}, B={-128,-128,-128,-128} -> result=65536, no overflow.
REQ-029 SHALL cover: A={127,-1,0,5}, B={2,-2,4,-6} -> result=226; A all 0 -> result=0.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready=0, and a new in_valid is ignored.
REQ-031 SHALL cover: rst asserted at the 4th RUN cycle -> gen_done and out_valid drop immediately; after release, the next operation A={1,2,3,4} gives 60.
REQ-032 SHALL cover: back-to-back operations with in_valid held high -> second accept exactly 1 cycle after the output handshake, with correct results for both.
